// File: rtl/fb_write_port.sv
// Frame-buffer pixel-write responder: clips (x,y), forms y*FB_W+x and writes RGB565 through a granted memory port.
// Define FB_BLEND_EN for read-modify-write saturating additive blend; default build overwrites.
module fb_write_port #(
  parameter int unsigned FB_W   = 240,
  parameter int unsigned FB_H   = 320,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        fb_x_i,
  input  logic [8:0]        fb_y_i,
  input  logic [15:0]       fb_color_i,
  input  logic              fb_req_i,
  output logic              fb_ack_o,
  output logic              drop_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [15:0]       mem_rdata_i,
  input  logic              mem_gnt_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DROP,
    S_WRITE
`ifdef FB_BLEND_EN
    , S_RD,
    S_MERGE
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              ack_q, ack_d;
  logic              drop_q, drop_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;

  logic              in_range;
  logic [ADDR_W-1:0] pix_addr;

  assign in_range = (32'(fb_x_i) < FB_W) && (32'(fb_y_i) < FB_H);
  assign pix_addr = ADDR_W'(fb_y_i) * ADDR_W'(FB_W) + ADDR_W'(fb_x_i);

`ifdef FB_BLEND_EN
  logic re_q, re_d;

  function automatic logic [15:0] blend565(input logic [15:0] a, input logic [15:0] b);
    logic [5:0] r;
    logic [6:0] g;
    logic [5:0] bl;
    r  = {1'b0, a[15:11]} + {1'b0, b[15:11]};
    g  = {1'b0, a[10:5]}  + {1'b0, b[10:5]};
    bl = {1'b0, a[4:0]}   + {1'b0, b[4:0]};
    return {r[5] ? 5'h1F : r[4:0], g[6] ? 6'h3F : g[5:0], bl[5] ? 5'h1F : bl[4:0]};
  endfunction
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata_i;
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    drop_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef FB_BLEND_EN
    re_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (fb_req_i) begin
          ack_d   = 1'b1;
          wdata_d = fb_color_i;
          if (in_range) begin
            addr_d = pix_addr;
`ifdef FB_BLEND_EN
            state_d = S_RD;
            re_d    = 1'b1;
`else
            state_d = S_WRITE;
            we_d    = 1'b1;
`endif
          end else begin
            state_d = S_DROP;
            drop_d  = 1'b1;
          end
        end
      end
      S_DROP: state_d = S_IDLE;
      S_WRITE: begin
        // we_q is high for the whole stay in WRITE, so the grant alone commits
        if (mem_gnt_i) state_d = S_IDLE;
        else           we_d    = 1'b1;
      end
`ifdef FB_BLEND_EN
      S_RD: begin
        if (mem_gnt_i) state_d = S_MERGE;
        else           re_d    = 1'b1;
      end
      S_MERGE: begin
        wdata_d = blend565(mem_rdata_i, wdata_q);
        state_d = S_WRITE;
        we_d    = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef FB_BLEND_EN
      re_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef FB_BLEND_EN
      re_q    <= re_d;
`endif
    end
  end

  assign fb_ack_o    = ack_q;
  assign drop_o      = drop_q;
  assign mem_we_o    = we_q;
  assign busy_o      = busy_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
`ifdef FB_BLEND_EN
  assign mem_re_o    = re_q;
`else
  assign mem_re_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fb_write_port.sv
// Scoreboard bench for fb_write_port: expected writes queued at stimulus time, compared against the commit log.
module tb_fb_write_port;
  localparam int unsigned AW = 17;
  typedef logic [AW+15:0] wr_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    fb_x_i = '0;
  logic [8:0]    fb_y_i = '0;
  logic [15:0]   fb_color_i = '0;
  logic          fb_req_i = 1'b0;
  logic          fb_ack_o, drop_o, mem_we_o, mem_re_o, busy_o;
  logic [AW-1:0] mem_addr_o;
  logic [15:0]   mem_wdata_o;
  logic [15:0]   mem_rdata_i = '0;
  logic          mem_gnt_i = 1'b1;

  fb_write_port #(.FB_W(240), .FB_H(320), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .fb_x_i(fb_x_i), .fb_y_i(fb_y_i),
    .fb_color_i(fb_color_i), .fb_req_i(fb_req_i), .fb_ack_o(fb_ack_o),
    .drop_o(drop_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata_i),
    .mem_gnt_i(mem_gnt_i), .busy_o(busy_o)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  wr_t exp_q[$];
  wr_t commit_log [0:255];
  int unsigned commit_cnt = 0, ack_cnt = 0, drop_cnt = 0, we_cnt = 0, re_cnt = 0;
  logic [15:0] rd_word = '0;

  // Mid-cycle monitor: a write commits on the edge after a cycle with we && gnt
  always @(negedge clock) begin
    if (fb_ack_o) ack_cnt++;
    if (drop_o) drop_cnt++;
    if (mem_we_o) we_cnt++;
    if (mem_re_o) re_cnt++;
    if (mem_we_o && mem_gnt_i) begin
      if (commit_cnt < 256) commit_log[commit_cnt] = {mem_addr_o, mem_wdata_o};
      commit_cnt++;
    end
  end

  always @(posedge clock)
    if (mem_re_o && mem_gnt_i) mem_rdata_i <= rd_word;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] blend_ref(input logic [15:0] o, input logic [15:0] n);
    int r, g, b;
    r = int'(o[15:11]) + int'(n[15:11]); if (r > 31) r = 31;
    g = int'(o[10:5])  + int'(n[10:5]);  if (g > 63) g = 63;
    b = int'(o[4:0])   + int'(n[4:0]);   if (b > 31) b = 31;
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  task automatic push_exp(input int x, input int y, input logic [15:0] c);
    logic [15:0] d;
`ifdef FB_BLEND_EN
    d = blend_ref(rd_word, c);
`else
    d = c;
`endif
    exp_q.push_back({AW'(y * 240 + x), d});
  endtask

  task automatic drive(input int x, input int y, input logic [15:0] c);
    fb_x_i = 8'(x); fb_y_i = 9'(y); fb_color_i = c; fb_req_i = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    tests_run++;
    if ({fb_ack_o, drop_o, mem_we_o, mem_re_o, busy_o, mem_addr_o, mem_wdata_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got ack=%b drop=%b we=%b re=%b busy=%b addr=%0d data=%h, want all 0",
               fb_ack_o, drop_o, mem_we_o, mem_re_o, busy_o, mem_addr_o, mem_wdata_o);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    int unsigned base = commit_cnt;
    exp_q.delete();
    rd_word = 16'h0000; mem_gnt_i = 1'b1;
    drive(3, 2, 16'hF800); push_exp(3, 2, 16'hF800);
    step();
    tests_run++;
    if (fb_ack_o !== 1'b1) begin tests_failed++; $display("FAIL single_ack_c1: got %b want 1", fb_ack_o); end
`ifndef FB_BLEND_EN
    tests_run++;
    if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 17'd483, 16'hF800}) begin
      tests_failed++;
      $display("FAIL single_write_c1: got we=%b addr=%0d data=%h want we=1 addr=483 data=f800", mem_we_o, mem_addr_o, mem_wdata_o);
    end
    fb_req_i = 1'b0;
    step();
    tests_run++;
    if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL single_busy_c2: got %b want 0", busy_o); end
`else
    tests_run++;
    if ({mem_re_o, mem_we_o} !== 2'b10) begin tests_failed++; $display("FAIL single_rd_c1: got re=%b we=%b want re=1 we=0", mem_re_o, mem_we_o); end
    fb_req_i = 1'b0;
`endif
    for (int i = 0; i < 40 && busy_o !== 1'b0; i++) step();
    tests_run++;
    if (commit_cnt - base != 1 || commit_log[base] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL single_commit: got %0d commits first=%h want 1 commit %h", commit_cnt - base, commit_log[base], exp_q[0]);
    end
  endtask

  task automatic test_grant_stall();
    int unsigned base = commit_cnt;
    exp_q.delete();
    rd_word = 16'h0000;
    mem_gnt_i = 1'b0;
    drive(100, 200, 16'h1357); push_exp(100, 200, 16'h1357);
    step();
    tests_run++;
    if (fb_ack_o !== 1'b1) begin tests_failed++; $display("FAIL stall_ack_c1: got %b want 1", fb_ack_o); end
    fb_req_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
`ifndef FB_BLEND_EN
      tests_run++;
      if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 17'd48100, 16'h1357} || commit_cnt != base) begin
        tests_failed++;
        $display("FAIL stall_hold_c%0d: got we=%b addr=%0d data=%h commits=%0d want we=1 addr=48100 data=1357 commits=0",
                 c, mem_we_o, mem_addr_o, mem_wdata_o, commit_cnt - base);
      end
`endif
      step();
    end
    mem_gnt_i = 1'b1;
`ifndef FB_BLEND_EN
    tests_run++;
    if (mem_we_o !== 1'b1) begin tests_failed++; $display("FAIL stall_we_c6: got %b want 1", mem_we_o); end
    step();
    tests_run++;
    if ({mem_we_o, busy_o} !== 2'b00 || commit_cnt - base != 1) begin
      tests_failed++;
      $display("FAIL stall_done_c7: got we=%b busy=%b commits=%0d want 0 0 1", mem_we_o, busy_o, commit_cnt - base);
    end
`endif
    for (int i = 0; i < 40 && busy_o !== 1'b0; i++) step();
    tests_run++;
    if (commit_cnt - base != 1 || commit_log[base] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL stall_commit: got %0d commits first=%h want 1 commit %h", commit_cnt - base, commit_log[base], exp_q[0]);
    end
  endtask

  task automatic test_clip();
    int unsigned base = commit_cnt, we0 = we_cnt, a0 = ack_cnt, d0 = drop_cnt;
    mem_gnt_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) drive(240, 0, 16'hFFFF); else drive(0, 320, 16'hFFFF);
      step();
      tests_run++;
      if ({fb_ack_o, drop_o, mem_we_o, mem_re_o} !== 4'b1100) begin
        tests_failed++;
        $display("FAIL clip%0d_c1: got ack=%b drop=%b we=%b re=%b want 1 1 0 0", k, fb_ack_o, drop_o, mem_we_o, mem_re_o);
      end
      fb_req_i = 1'b0;
      step();
      tests_run++;
      if ({fb_ack_o, drop_o, busy_o} !== 3'b000) begin
        tests_failed++;
        $display("FAIL clip%0d_c2: got ack=%b drop=%b busy=%b want 0 0 0", k, fb_ack_o, drop_o, busy_o);
      end
    end
    step();
    tests_run++;
    if (ack_cnt - a0 != 2 || drop_cnt - d0 != 2 || we_cnt != we0 || commit_cnt != base) begin
      tests_failed++;
      $display("FAIL clip_totals: got acks=%0d drops=%0d we_cycles=%0d commits=%0d want 2 2 0 0",
               ack_cnt - a0, drop_cnt - d0, we_cnt - we0, commit_cnt - base);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned base = commit_cnt, a0 = ack_cnt;
    bit got;
    exp_q.delete();
    rd_word = 16'h0000; mem_gnt_i = 1'b1;
    drive(10, 2, 16'h001F); push_exp(10, 2, 16'h001F);
    step();
    tests_run++;
    if (fb_ack_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_ack1: got %b want 1", fb_ack_o); end
    step();
    drive(5, 5, 16'h07E0); push_exp(5, 5, 16'h07E0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = fb_ack_o;
    end
`ifndef FB_BLEND_EN
    tests_run++;
    if ({fb_ack_o, mem_addr_o, mem_wdata_o} !== {1'b1, 17'd1205, 16'h07E0}) begin
      tests_failed++;
      $display("FAIL b2b_second_c3: got ack=%b addr=%0d data=%h want 1 1205 07e0", fb_ack_o, mem_addr_o, mem_wdata_o);
    end
`endif
    fb_req_i = 1'b0;
    for (int i = 0; i < 40 && busy_o !== 1'b0; i++) step();
    step(); step();
    tests_run++;
    if (!got || ack_cnt - a0 != 2 || commit_cnt - base != 2) begin
      tests_failed++;
      $display("FAIL b2b_counts: got acks=%0d commits=%0d want 2 2", ack_cnt - a0, commit_cnt - base);
    end
    for (int unsigned k = 0; k < 2; k++) begin
      tests_run++;
      if (commit_log[base + k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL b2b_commit%0d: got %h want %h", k, commit_log[base + k], exp_q[k]);
      end
    end
  endtask

  task automatic test_blend();
    int unsigned base = commit_cnt, r0 = re_cnt;
    logic [15:0] olds [2];
    logic [15:0] news [2];
    olds[0] = 16'h8410; news[0] = 16'h8410;
    olds[1] = 16'h0000; news[1] = 16'h1234;
    exp_q.delete();
    mem_gnt_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rd_word = olds[k];
      drive(k, 7, news[k]); push_exp(k, 7, news[k]);
      step();
      fb_req_i = 1'b0;
      for (int i = 0; i < 40 && busy_o !== 1'b0; i++) step();
      step();
    end
`ifdef FB_BLEND_EN
    tests_run++;
    if (exp_q[0] !== {17'd1680, 16'hFFFF} || exp_q[1] !== {17'd1681, 16'h1234}) begin
      tests_failed++;
      $display("FAIL blend_model: got %h %h want 1680/ffff 1681/1234", exp_q[0], exp_q[1]);
    end
    tests_run++;
    if (re_cnt - r0 != 2) begin tests_failed++; $display("FAIL blend_reads: got %0d want 2", re_cnt - r0); end
`else
    tests_run++;
    if (re_cnt != r0) begin tests_failed++; $display("FAIL blend_re_low: got %0d re cycles want 0", re_cnt - r0); end
`endif
    for (int unsigned k = 0; k < 2; k++) begin
      tests_run++;
      if (commit_cnt - base != 2 || commit_log[base + k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL blend_commit%0d: got %h (commits=%0d) want %h", k, commit_log[base + k], commit_cnt - base, exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_in_write();
    int unsigned base;
    exp_q.delete();
    mem_gnt_i = 1'b0;
    drive(7, 7, 16'hAAAA);
    step();
    reset = 1'b1; fb_req_i = 1'b0;
    step();
    reset = 1'b0;
    tests_run++;
    if ({mem_we_o, mem_re_o, fb_ack_o, busy_o} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_mid: got we=%b re=%b ack=%b busy=%b want 0 0 0 0", mem_we_o, mem_re_o, fb_ack_o, busy_o);
    end
    base = commit_cnt;
    mem_gnt_i = 1'b1;
    step(); step(); step();
    tests_run++;
    if (commit_cnt != base) begin tests_failed++; $display("FAIL rst_no_commit: got %0d commits want 0", commit_cnt - base); end
    rd_word = 16'h0000;
    drive(1, 0, 16'h5555); push_exp(1, 0, 16'h5555);
    step();
    tests_run++;
    if (fb_ack_o !== 1'b1) begin tests_failed++; $display("FAIL rst_after_ack: got %b want 1", fb_ack_o); end
    fb_req_i = 1'b0;
    for (int i = 0; i < 40 && busy_o !== 1'b0; i++) step();
    step();
    tests_run++;
    if (commit_cnt - base != 1 || commit_log[base] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL rst_after_commit: got %0d commits first=%h want 1 commit %h", commit_cnt - base, commit_log[base], exp_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_grant_stall();
    test_clip();
    test_back_to_back();
    test_blend();
    test_reset_in_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/fb_write_port.md
# fb_write_port

Frame-buffer write responder: the target side of the `fb_x/fb_y/fb_color/fb_req/fb_ack` pixel-write handshake that the figure drawers issue. It accepts one pixel per transaction and clips it against the screen. It converts (x, y) to a linear word address and writes the RGB565 value into the frame-buffer memory through a granted, shared memory port. Scan-out owns that port when `mem_gnt_i` is low.

## Interface
- `FB_W`, 240: screen width in pixels.
- `FB_H`, 320: screen height in pixels.
- `ADDR_W`, 17: memory word-address width; must satisfy FB_W*FB_H ≤ 2^ADDR_W.

Reset is synchronous and active-high; one clock.
- `clock` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `fb_x_i` in 8: pixel x
- `fb_y_i` in 9: pixel y
- `fb_color_i` in 16: RGB565 `{r[4:0], g[5:0], b[4:0]}`
- `fb_req_i` in 1: request level, held by the requester until acked
- `fb_ack_o` out 1: one-cycle pulse; the transaction is consumed
- `drop_o` out 1: one-cycle pulse; the pixel was clipped (coincides with ack)
- `mem_addr_o` out ADDR_W: word address
- `mem_wdata_o` out 16: write data
- `mem_we_o` out 1: write request
- `mem_re_o` out 1: read request (blend builds only)
- `mem_rdata_i` in 16: read data, valid 1 cycle after the read commits
- `mem_gnt_i` in 1: port granted this cycle
- `busy_o` out 1: FSM not in IDLE

## Operation
- States: IDLE, DROP, RD, MERGE, WRITE. RD and MERGE exist only in blend builds.
- **IDLE**
  - Samples `fb_req_i`. If set, it latches x, y and color at the clock edge.
  - In range (x < FB_W and y < FB_H): latch `addr = y*FB_W + x`, computed in ADDR_W bits. Go to WRITE, or to RD in blend builds.
  - Out of range: go to DROP.
- **DROP**: `fb_ack_o = drop_o = 1` for one cycle, then IDLE. No memory access.
- **WRITE**
  - `mem_we_o` is held high with stable address and data.
  - The write commits in a cycle where `mem_we_o && mem_gnt_i`; the FSM leaves for IDLE on that edge.
- **Ack**
  - `fb_ack_o` is a registered pulse, high in the first cycle after capture, in the DROP, WRITE or RD state.
  - Because the FSM is never in IDLE during the ack cycle, the still-high `fb_req_i` in that cycle is never re-accepted.
  - `fb_req_i` high in the cycle after the ack is a new transaction with new data.
- **Handshake rules**
  - Inputs are sampled only in IDLE with `fb_req_i` high.
  - The ack never depends on `mem_gnt_i`.
  - At most one transaction is outstanding.
- **Reset values**: state IDLE; `fb_ack_o`, `drop_o`, `mem_we_o`, `mem_re_o` and `busy_o` are 0; `mem_addr_o` and `mem_wdata_o` are 0.
- **Reset mid-transaction**: the transaction is abandoned; no write or read is issued after the reset cycle. If the reset lands in the ack cycle, `fb_ack_o` goes low on the next cycle.

## Timing
- Request sampled in cycle 0 → `fb_ack_o` and `mem_we_o` in cycle 1.
- With `mem_gnt_i=1`, the write commits in cycle 1 and IDLE is back in cycle 2.
- Throughput: one pixel per 2 cycles. Grant stalls add 1 cycle each.
- Blend build: RD in cycle 1 with `mem_re_o` until granted. MERGE is the cycle after the read commits: `mem_rdata_i` is valid, and the sum is registered into `mem_wdata_o`. WRITE follows. Minimum 4 cycles per pixel.
- Clipped pixel: ack in cycle 1, IDLE in cycle 2.

## Configuration
- `FB_BLEND_EN` defined:
  - Read-modify-write additive blend: each channel is `min(old + new, max)`.
  - R and B saturate at 31, G at 63.
  - The read commits before the write, in the same transaction.
- `FB_BLEND_EN` undefined:
  - Plain overwrite; RD and MERGE are absent.
  - `mem_re_o` is tied to 0 and `mem_rdata_i` is unused.

## Test plan
- **Single write**: x=3, y=2, color 0xF800, gnt=1. Ack in cycle 1, `mem_we_o` in cycle 1 with addr 483 and data 0xF800, `busy_o` low in cycle 2.
- **Grant stall**: gnt low for cycles 1–5, then high. `mem_we_o` is held for 6 cycles with stable addr/data; exactly one commit, in cycle 6; the ack is still in cycle 1.
- **Clip**: x=240, y=0, then x=0, y=320. Each gives one `fb_ack_o` and one `drop_o` pulse, and `mem_we_o` never rises.
- **Back-to-back**: req is held high across the ack with new data (5,5,0x07E0) presented in the cycle after the ack. Two acks and two commits, to addr 5*240+5=1205 and the first address; no duplicate commit.
- **Blend, `FB_BLEND_EN`**: old word 0x8410 plus new 0x8410 writes 0xFFFF. Old word 0x0000 plus 0x1234 writes 0x1234. Without the macro, 0x8410 is written and `mem_re_o` stays 0.
- **Reset in WRITE** with gnt=0: `mem_we_o`, `fb_ack_o` and `busy_o` are 0 from the next cycle. A later request is accepted normally.
